// File: rtl/l15_mem_responder.sv
package wt_cache_pkg;
  localparam int unsigned PLEN               = 40;
  localparam int unsigned L15_TID_WIDTH      = 2;
  localparam int unsigned L1D_WAY_WIDTH      = 3;
  localparam int unsigned L15_TLB_CSM_WIDTH  = 33;

  typedef enum logic [4:0] {
    L15_LOAD_RQ    = 5'b00000,
    L15_IMISS_RQ   = 5'b10000,
    L15_STORE_RQ   = 5'b00001,
    L15_ATOMIC_RQ  = 5'b00110,
    L15_STRLOAD_RQ = 5'b00100,
    L15_STRST_RQ   = 5'b00101,
    L15_INT_RQ     = 5'b01001,
    L15_FWD_RQ     = 5'b01101,
    L15_FWD_RPY    = 5'b01110,
    L15_RSVD_RQ    = 5'b11111
  } l15_reqtypes_t;

  typedef enum logic [3:0] {
    L15_LOAD_RET    = 4'b0000,
    L15_IFILL_RET   = 4'b0001,
    L15_STRLOAD_RET = 4'b0010,
    L15_EVICT_REQ   = 4'b0011,
    L15_ST_ACK      = 4'b0100,
    L15_TEST_RET    = 4'b0101,
    L15_STRST_ACK   = 4'b0110,
    L15_INT_RET     = 4'b0111,
    L15_FP_RET      = 4'b1000,
    L15_ERR_RET     = 4'b1100,
    L15_ATOMIC_RET  = 4'b1110,
    L15_RSVD_RET    = 4'b1111
  } l15_rtrn_types_t;

  typedef struct packed {
    logic                          l15_val;
    logic                          l15_req_ack;
    l15_reqtypes_t                 l15_rqtype;
    logic                          l15_nc;
    logic [2:0]                    l15_size;
    logic [L15_TID_WIDTH-1:0]      l15_threadid;
    logic                          l15_prefetch;
    logic                          l15_invalidate_cacheline;
    logic                          l15_blockstore;
    logic                          l15_blockinitstore;
    logic [L1D_WAY_WIDTH-1:0]      l15_l1rplway;
    logic [PLEN-1:0]               l15_address;
    logic [63:0]                   l15_data;
    logic [63:0]                   l15_data_next_entry;
    logic [L15_TLB_CSM_WIDTH-1:0]  l15_csm_data;
    logic [3:0]                    l15_amo_op;
  } l15_req_t;

  typedef struct packed {
    logic                          l15_ack;
    logic                          l15_header_ack;
    logic                          l15_val;
    l15_rtrn_types_t               l15_returntype;
    logic                          l15_l2miss;
    logic [1:0]                    l15_error;
    logic                          l15_noncacheable;
    logic                          l15_atomic;
    logic [L15_TID_WIDTH-1:0]      l15_threadid;
    logic                          l15_prefetch;
    logic                          l15_f4b;
    logic [63:0]                   l15_data_0;
    logic [63:0]                   l15_data_1;
    logic [63:0]                   l15_data_2;
    logic [63:0]                   l15_data_3;
    logic                          l15_inval_icache_all_way;
    logic                          l15_inval_dcache_all_way;
    logic [15:4]                   l15_inval_address_15_4;
    logic                          l15_cross_invalidate;
    logic [L1D_WAY_WIDTH-1:0]      l15_cross_invalidate_way;
    logic                          l15_inval_dcache_inval;
    logic                          l15_inval_icache_inval;
    logic [L1D_WAY_WIDTH-1:0]      l15_inval_way;
    logic                          l15_blockinitstore;
  } l15_rtrn_t;
endpackage

module l15_mem_responder #(
  parameter int unsigned MemWords = 4096,
  parameter int unsigned Latency  = 4,
  parameter string       InitFile = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  wt_cache_pkg::l15_req_t  l15_req_i,
  output wt_cache_pkg::l15_rtrn_t l15_rtrn_o,
  output logic                    busy_o,
  output logic [15:0]             unsup_cnt_o
);
  import wt_cache_pkg::*;

  localparam int unsigned IdxW  = $clog2(MemWords);
  localparam logic [7:0]  LatM1 = 8'(Latency - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d, lat_load;
  logic                     accept;
  logic [IdxW-1:0]          idx;
  logic [63:0]              st_base, st_mask;
  l15_rtrn_types_t          rtype_q;
  logic                     nc_q;
  logic [L15_TID_WIDTH-1:0] tid_q;
  logic [63:0]              d0_q, d1_q, d2_q, d3_q;
  logic [15:0]              unsup_q;
  logic                     unused_req;

  logic [63:0] mem [MemWords];

  assign unused_req = ^l15_req_i;

  assign accept = (state_q == IDLE) && l15_req_i.l15_val && !rst_i;
  assign idx    = l15_req_i.l15_address[3 +: IdxW];

  // Big-endian lanes: left-justified run shifted right by 8*offset.
  always_comb begin
    case (l15_req_i.l15_size[1:0])
      2'd0:    st_base = 64'hFF00_0000_0000_0000;
      2'd1:    st_base = 64'hFFFF_0000_0000_0000;
      2'd2:    st_base = 64'hFFFF_FFFF_0000_0000;
      default: st_base = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    st_mask = st_base >> {l15_req_i.l15_address[2:0], 3'b000};
  end

`ifdef L15_RESP_RANDOM_LATENCY_EN
  logic [15:0] lfsr_q;
  logic [8:0]  lat_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign lat_sum  = {1'b0, LatM1} + {5'd0, lfsr_q[3:0]};
  assign lat_load = (lat_sum > 9'd254) ? 8'd254 : lat_sum[7:0];
`else
  assign lat_load = LatM1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = lat_load;
          state_d = (lat_load == 8'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (l15_req_i.l15_req_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      rtype_q <= L15_LOAD_RET;
      nc_q    <= 1'b0;
      tid_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      unsup_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        nc_q  <= l15_req_i.l15_nc;
        tid_q <= l15_req_i.l15_threadid;
        d0_q  <= '0;
        d1_q  <= '0;
        d2_q  <= '0;
        d3_q  <= '0;
        case (l15_req_i.l15_rqtype)
          L15_LOAD_RQ: begin
            rtype_q <= L15_LOAD_RET;
            d0_q    <= mem[{idx[IdxW-1:1], 1'b0}];
            d1_q    <= mem[{idx[IdxW-1:1], 1'b1}];
          end
          L15_IMISS_RQ: begin
            rtype_q <= L15_IFILL_RET;
            d0_q    <= mem[{idx[IdxW-1:2], 2'd0}];
            d1_q    <= mem[{idx[IdxW-1:2], 2'd1}];
            d2_q    <= mem[{idx[IdxW-1:2], 2'd2}];
            d3_q    <= mem[{idx[IdxW-1:2], 2'd3}];
          end
          L15_STORE_RQ: rtype_q <= L15_ST_ACK;
          default: begin
            rtype_q <= L15_ST_ACK;
            if (unsup_q != 16'hFFFF) unsup_q <= unsup_q + 16'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && (l15_req_i.l15_rqtype == L15_STORE_RQ))
      mem[idx] <= (mem[idx] & ~st_mask) | (l15_req_i.l15_data & st_mask);
  end

  always_comb begin
    l15_rtrn_o                  = '0;
    l15_rtrn_o.l15_header_ack   = accept;
    l15_rtrn_o.l15_ack          = accept;
    l15_rtrn_o.l15_val          = (state_q == RESP);
    l15_rtrn_o.l15_returntype   = rtype_q;
    l15_rtrn_o.l15_noncacheable = nc_q;
    l15_rtrn_o.l15_threadid     = tid_q;
    l15_rtrn_o.l15_data_0       = d0_q;
    l15_rtrn_o.l15_data_1       = d1_q;
    l15_rtrn_o.l15_data_2       = d2_q;
    l15_rtrn_o.l15_data_3       = d3_q;
    busy_o                      = (state_q != IDLE);
    unsup_cnt_o                 = unsup_q;
  end

endmodule

// File: tb/tb_l15_mem_responder.sv
module tb_l15_mem_responder;
    import wt_cache_pkg::*;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    l15_req_t    req;
    l15_rtrn_t   rtrn;
    logic        busy;
    logic [15:0] unsup;

    int total = 0;
    int bad   = 0;

    l15_mem_responder #(
        .MemWords (64),
        .Latency  (LAT),
        .InitFile ("")
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .l15_req_i   (req),
        .l15_rtrn_o  (rtrn),
        .busy_o      (busy),
        .unsup_cnt_o (unsup)
    );

    always #5 clk = ~clk;

    typedef struct {
        l15_reqtypes_t   rq;
        logic [2:0]      sz;
        logic [39:0]     addr;
        logic [63:0]     data;
        l15_rtrn_types_t ert;
        logic [63:0]     e0, e1, e2, e3;
    } vec_t;

    vec_t vecs[$];

    function automatic void chk(input string nm, input string what,
                                input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
        end
    endfunction

    function automatic vec_t mk(input l15_reqtypes_t rq, input logic [2:0] sz,
                                input logic [39:0] a, input logic [63:0] d,
                                input l15_rtrn_types_t ert, input logic [63:0] e0,
                                input logic [63:0] e1, input logic [63:0] e2,
                                input logic [63:0] e3);
        vec_t v;
        v.rq = rq; v.sz = sz; v.addr = a; v.data = d; v.ert = ert;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic [1:0] tid, input logic nc);
        req.l15_rqtype   = v.rq;
        req.l15_size     = v.sz;
        req.l15_address  = v.addr;
        req.l15_data     = v.data;
        req.l15_threadid = tid;
        req.l15_nc       = nc;
        req.l15_val      = 1'b1;
    endtask

    // Wait for l15_val; returns cycles counted from the accept cycle.
    task automatic wait_val(output int lat);
        lat = 1;
        while (!rtrn.l15_val && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_resp(input string nm, input vec_t v, input logic [1:0] tid,
                              input logic nc);
        chk(nm, "rtype", 64'(rtrn.l15_returntype), 64'(v.ert));
        chk(nm, "d0", rtrn.l15_data_0, v.e0);
        chk(nm, "d1", rtrn.l15_data_1, v.e1);
        chk(nm, "d2", rtrn.l15_data_2, v.e2);
        chk(nm, "d3", rtrn.l15_data_3, v.e3);
        chk(nm, "tid", 64'(rtrn.l15_threadid), 64'(tid));
        chk(nm, "nc", 64'(rtrn.l15_noncacheable), 64'(nc));
    endtask

    task automatic consume(input string nm);
        req.l15_req_ack = 1'b1;
        @(posedge clk); #1;
        req.l15_req_ack = 1'b0;
        chk(nm, "val_after", 64'(rtrn.l15_val), 64'd0);
        chk(nm, "busy_after", 64'(busy), 64'd0);
    endtask

    task automatic run_txn(input string nm, input vec_t v, input logic [1:0] tid,
                           input logic nc);
        int lat;
        @(negedge clk);
        drive(v, tid, nc);
        #1;
        chk(nm, "hdr_ack", 64'(rtrn.l15_header_ack), 64'd1);
        chk(nm, "ack", 64'(rtrn.l15_ack), 64'd1);
        @(posedge clk); #1;
        req.l15_val = 1'b0;
        chk(nm, "busy", 64'(busy), 64'd1);
        wait_val(lat);
        chk(nm, "latency", 64'(lat), 64'(LAT));
        check_resp(nm, v, tid, nc);
        consume(nm);
    endtask

    localparam logic [63:0] W8 = 64'h1122334455667788;
    localparam logic [63:0] AB = 64'hABABABABABABABAB;

    initial begin
        int   lat;
        int   vhigh;
        vec_t v;
        vec_t v2;

        req   = '0;
        rst_i = 1'b1;

        // Stores write words 0..7 = 0..7 so that fills read known data.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(L15_STORE_RQ, 3'd3, 40'(8 * i), 64'(i), L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_STORE_RQ, 3'd3, 40'h48, 64'd0, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_STORE_RQ, 3'd3, 40'h40, W8, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_LOAD_RQ, 3'd3, 40'h40, 64'd0, L15_LOAD_RET, W8, 0, 0, 0));
        vecs.push_back(mk(L15_LOAD_RQ, 3'd3, 40'h48, 64'd0, L15_LOAD_RET, W8, 0, 0, 0));
        vecs.push_back(mk(L15_LOAD_RQ, 3'd3, 40'h240, 64'd0, L15_LOAD_RET, W8, 0, 0, 0));
        vecs.push_back(mk(L15_IMISS_RQ, 3'd3, 40'h28, 64'd0, L15_IFILL_RET, 4, 5, 6, 7));
        vecs.push_back(mk(L15_IMISS_RQ, 3'd3, 40'h00, 64'd0, L15_IFILL_RET, 0, 1, 2, 3));
        vecs.push_back(mk(L15_IMISS_RQ, 3'd3, 40'h3F, 64'd0, L15_IFILL_RET, 4, 5, 6, 7));
        vecs.push_back(mk(L15_STORE_RQ, 3'd3, 40'h40, 64'd0, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_STORE_RQ, 3'd0, 40'h43, AB, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_STORE_RQ, 3'd0, 40'h4B, AB, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_LOAD_RQ, 3'd3, 40'h40, 64'd0, L15_LOAD_RET,
                          64'h000000AB00000000, 64'h000000AB00000000, 0, 0));
        vecs.push_back(mk(L15_STORE_RQ, 3'd1, 40'h46, 64'h1234567890ABCDEF, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_STORE_RQ, 3'd2, 40'h4C, 64'hFFFFFFFF5A5A5A5A, L15_ST_ACK, 0, 0, 0, 0));
        vecs.push_back(mk(L15_LOAD_RQ, 3'd3, 40'h48, 64'd0, L15_LOAD_RET,
                          64'h000000AB0000CDEF, 64'h000000AB5A5A5A5A, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset", "val", 64'(rtrn.l15_val), 64'd0);
        chk("reset", "busy", 64'(busy), 64'd0);
        chk("reset", "unsup", 64'(unsup), 64'd0);
        chk("reset", "d0", rtrn.l15_data_0, 64'd0);
        rst_i = 1'b0;

        // Table-driven transactions
        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i], 2'(i), 1'(i));

        // Reset while in WAIT drops the pending response
        v = mk(L15_LOAD_RQ, 3'd3, 40'h48, 64'd0, L15_LOAD_RET,
               64'h000000AB0000CDEF, 64'h000000AB5A5A5A5A, 0, 0);
        @(negedge clk);
        drive(v, 2'd1, 1'b0);
        @(posedge clk); #1;
        req.l15_val = 1'b0;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("midrst", "val", 64'(rtrn.l15_val), 64'd0);
        chk("midrst", "busy", 64'(busy), 64'd0);
        chk("midrst", "unsup", 64'(unsup), 64'd0);
        vhigh = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rtrn.l15_val) vhigh++;
        end
        chk("midrst", "stale_val", 64'(vhigh), 64'd0);
        run_txn("after_rst", v, 2'd2, 1'b1);

        // Held response with a second request pending
        v  = mk(L15_LOAD_RQ, 3'd3, 40'h40, 64'd0, L15_LOAD_RET,
                64'h000000AB0000CDEF, 64'h000000AB5A5A5A5A, 0, 0);
        v2 = mk(L15_IMISS_RQ, 3'd3, 40'h28, 64'd0, L15_IFILL_RET, 4, 5, 6, 7);
        @(negedge clk);
        drive(v, 2'd3, 1'b1);
        @(posedge clk); #1;
        req.l15_val = 1'b0;
        wait_val(lat);
        chk("hold", "latency", 64'(lat), 64'(LAT));
        for (int c = 0; c < 10; c++) begin
            if (c == 2) drive(v2, 2'd0, 1'b0);
            #1;
            chk($sformatf("hold%0d", c), "val", 64'(rtrn.l15_val), 64'd1);
            chk($sformatf("hold%0d", c), "d0", rtrn.l15_data_0, v.e0);
            chk($sformatf("hold%0d", c), "d1", rtrn.l15_data_1, v.e1);
            chk($sformatf("hold%0d", c), "hdr_ack", 64'(rtrn.l15_header_ack), 64'd0);
            @(posedge clk); #1;
        end
        check_resp("hold_end", v, 2'd3, 1'b1);
        req.l15_req_ack = 1'b1;
        @(posedge clk); #1;
        req.l15_req_ack = 1'b0;
        chk("b2b", "hdr_ack", 64'(rtrn.l15_header_ack), 64'd1);
        chk("b2b", "ack", 64'(rtrn.l15_ack), 64'd1);
        @(posedge clk); #1;
        req.l15_val = 1'b0;
        wait_val(lat);
        chk("b2b", "latency", 64'(lat), 64'(LAT));
        check_resp("b2b", v2, 2'd0, 1'b0);
        consume("b2b");

        // Unsupported request types
        v = mk(L15_ATOMIC_RQ, 3'd3, 40'h40, 64'hDEADBEEFDEADBEEF, L15_ST_ACK, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            run_txn($sformatf("atomic%0d", i), v, 2'(i), 1'b0);
        chk("unsup", "count", 64'(unsup), 64'd3);
        v = mk(L15_LOAD_RQ, 3'd3, 40'h40, 64'd0, L15_LOAD_RET,
               64'h000000AB0000CDEF, 64'h000000AB5A5A5A5A, 0, 0);
        run_txn("unsup_mem", v, 2'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
